// File: rtl/tensor_core_pkg.sv
// ---------------------------------------------------------------------------
// tensor_core_pkg
//   Shared types and constants for the tensor core scheduler slice.
//   - tc_sched_state_t : scheduler FSM state encoding
//   - TC_CORE_CYCLES   : compute latency of small_tensor_core, in cycles
//   - TC_JOB_COUNT_W   : width of the completed-job counter
// ---------------------------------------------------------------------------
package tensor_core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } tc_sched_state_t;

  localparam int TC_CORE_CYCLES = 64;
  localparam int TC_JOB_COUNT_W = 16;

endpackage

// File: rtl/round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
//   Purely combinational round-robin pick. The search starts at 'pointer'
//   and wraps around, so 'pointer' is the highest-priority index.
//
//   Ports:
//     request   [N-1:0]     one bit per requester
//     pointer   [IDX_W-1:0] index with highest priority (must be < N)
//     winner    [IDX_W-1:0] chosen index (0 when nothing is requested)
//     any_valid             at least one request bit is set
// ---------------------------------------------------------------------------
module round_robin_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] pointer,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  logic found;

  // Two ordered passes: first the indices at or above the pointer, then the
  // ones below it. The first hit in this order is the round-robin winner.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    any_valid = |request;
    for (int j = 0; j < N; j++) begin
      if (!found && request[j] && (j >= int'(pointer))) begin
        winner = IDX_W'(j);
        found  = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && request[j] && (j < int'(pointer))) begin
        winner = IDX_W'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tensor_core_scheduler.sv
// ---------------------------------------------------------------------------
// tensor_core_scheduler
//   Shares one small_tensor_core among NUM_REQ requesters. One job at a time:
//   pick a requester round-robin, pulse the core's write enable for one
//   cycle, wait for done (with a timeout watchdog), then present a response
//   to the owning requester until it is accepted or abandoned.
//
//   Handshake: a requester holds request_in[i] high until its job is
//   answered. response_valid_out[i] is high while the result is on offer;
//   the response is consumed on the rising edge where response_ready_in[i]
//   is also high. Dropping request_in[i] while the response is on offer
//   abandons it (consumed, but not counted as a completed job).
//   response_error_out qualifies response_valid_out: the job timed out and
//   the core result must be ignored.
//
//   Ports:
//     clock_in, reset_n_in    clock / async active-low reset
//     request_in              per-requester job request (level)
//     response_ready_in       per-requester response acceptance
//     core_is_done_in         done flag from the core
//     core_write_enable_out   one-cycle start pulse to the core
//     grant_valid_out         a job owns the core; grant_id_out is valid
//     grant_id_out            owning requester, drives operand/result mux
//     response_valid_out      one-hot response strobe
//     response_error_out      response carries a timeout error
//     timeout_error_out       sticky: a timeout happened since reset
//     busy_out                scheduler not idle
//     job_count_out           successfully completed jobs (wraps)
//     state_dbg_out           current FSM state, for observation only
// ---------------------------------------------------------------------------
module tensor_core_scheduler
  import tensor_core_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 80,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      clock_in,
  input  logic                      reset_n_in,
  input  logic [NUM_REQ-1:0]        request_in,
  input  logic [NUM_REQ-1:0]        response_ready_in,
  input  logic                      core_is_done_in,
  output logic                      core_write_enable_out,
  output logic                      grant_valid_out,
  output logic [ID_W-1:0]           grant_id_out,
  output logic [NUM_REQ-1:0]        response_valid_out,
  output logic                      response_error_out,
  output logic                      timeout_error_out,
  output logic                      busy_out,
  output logic [TC_JOB_COUNT_W-1:0] job_count_out,
  output tc_sched_state_t           state_dbg_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  tc_sched_state_t           state_q;
  logic [ID_W-1:0]           grant_id_q;
  logic [ID_W-1:0]           rr_ptr_q;
  logic [CNT_W-1:0]          wait_cnt_q;
  logic                      error_q;
  logic                      timeout_sticky_q;
  logic [TC_JOB_COUNT_W-1:0] job_count_q;

  logic [ID_W-1:0]           arb_winner;
  logic                      arb_any;
  logic                      done_accept;
  logic                      granted_ready;
  logic                      granted_request;
  logic                      rsp_release;
  logic [ID_W-1:0]           next_ptr;

  round_robin_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arbiter (
    .request   (request_in),
    .pointer   (rr_ptr_q),
    .winner    (arb_winner),
    .any_valid (arb_any)
  );

  // The core's done flag stays high from the previous job until the new
  // start pulse is taken, so the first WAIT cycle (counter still 0) must
  // not trust it.
  assign done_accept     = core_is_done_in && (wait_cnt_q != '0);

  assign granted_ready   = response_ready_in[grant_id_q];
  assign granted_request = request_in[grant_id_q];
  assign rsp_release     = granted_ready || !granted_request;

  // Next round-robin start: the requester after the one just served.
  assign next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q          <= IDLE;
      grant_id_q       <= '0;
      rr_ptr_q         <= '0;
      wait_cnt_q       <= '0;
      error_q          <= 1'b0;
      timeout_sticky_q <= 1'b0;
      job_count_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_id_q <= arb_winner;
            state_q    <= LOAD;
          end
        end

        LOAD: begin
          wait_cnt_q <= '0;
          error_q    <= 1'b0;
          state_q    <= WAIT;
        end

        WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          // done wins over the watchdog when both land in the same cycle.
          if (done_accept) begin
            error_q <= 1'b0;
            state_q <= RESULT;
          end else if (wait_cnt_q == CNT_LAST) begin
            error_q          <= 1'b1;
            timeout_sticky_q <= 1'b1;
            state_q          <= RESULT;
          end
        end

        RESULT: begin
          if (rsp_release) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
            // Abandoned or timed-out jobs are not counted.
            if (!error_q && granted_ready) begin
              job_count_q <= job_count_q + 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode from registered state, so an asynchronous reset
  // clears them without waiting for a clock edge.
  assign core_write_enable_out = (state_q == LOAD);
  assign grant_valid_out       = (state_q != IDLE);
  assign busy_out              = (state_q != IDLE);
  assign grant_id_out          = grant_id_q;
  assign response_valid_out    = (state_q == RESULT) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign response_error_out    = (state_q == RESULT) && error_q;
  assign timeout_error_out     = timeout_sticky_q;
  assign job_count_out         = job_count_q;
  assign state_dbg_out         = state_q;

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tensor_core_scheduler
//   Bench for tensor_core_scheduler with a behavioural small_tensor_core
//   model (done rises TC_CORE_CYCLES edges after the start pulse is taken).
// ---------------------------------------------------------------------------
module tb_tensor_core_scheduler;
  import tensor_core_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 66;   // edge 0 (request sampled) to response valid
  localparam int TO  = 81;   // edge 0 to response valid on timeout

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]      req;
  logic [3:0]      rdy;
  logic            done;
  logic            we;
  logic            gv;
  logic [1:0]      gid;
  logic [3:0]      rv;
  logic            re;
  logic            te;
  logic            busy;
  logic [15:0]     jc;
  tc_sched_state_t state_dbg;

  tensor_core_scheduler #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (80)
  ) dut (
    .clock_in              (clk),
    .reset_n_in            (rst_n),
    .request_in            (req),
    .response_ready_in     (rdy),
    .core_is_done_in       (done),
    .core_write_enable_out (we),
    .grant_valid_out       (gv),
    .grant_id_out          (gid),
    .response_valid_out    (rv),
    .response_error_out    (re),
    .timeout_error_out     (te),
    .busy_out              (busy),
    .job_count_out         (jc),
    .state_dbg_out         (state_dbg)
  );

  // ---------------- core model ----------------
  // core_mode: 0 = normal core, 1 = never done, 2 = done stuck high
  int   core_mode = 0;
  int   core_cnt  = 0;
  logic core_run  = 1'b0;
  logic core_done = 1'b0;

  always @(posedge clk) begin
    if (we) begin
      core_run  <= 1'b1;
      core_cnt  <= 1;
      core_done <= 1'b0;
    end else if (core_run) begin
      if (core_cnt == TC_CORE_CYCLES) begin
        core_done <= 1'b1;
        core_run  <= 1'b0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  assign done = (core_mode == 1) ? 1'b0 : (core_mode == 2) ? 1'b1 : core_done;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          ref_ptr = 0;
  logic [15:0] ref_count = '0;
  logic [1:0]  exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'h0;
    rdy = 4'h0;
    core_mode = 0;
    tick();
    tick();
    rst_n = 1'b1;
    ref_ptr = 0;
    ref_count = '0;
    exp_q.delete();
  endtask

  // Runs n_jobs jobs for a static request pattern. The expected grant order
  // comes from a plain round-robin walk over the pending set.
  task automatic run_jobs(input logic [3:0] pattern, input bit hold, input int n_jobs,
                          input bit rand_ready, input string tag);
    logic [3:0] pend;
    logic [3:0] mask;
    logic [1:0] exp_g;
    int ptr, w, idx, jobs_done, cyc, we_cyc, we_pulses;
    bit seen_rv, shook;
    pend = pattern;
    ptr = ref_ptr;
    for (int j = 0; j < n_jobs; j++) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (w < 0 && ((pend >> idx) & 4'd1) != 4'd0) w = idx;
      end
      if (w >= 0) begin
        exp_q.push_back(2'(w));
        ptr = (w + 1) % N;
        if (!hold) pend = pend & ~(4'd1 << w);
      end
    end
    ref_ptr = ptr;
    req = pattern;
    rdy = rand_ready ? 4'h0 : 4'hF;
    jobs_done = 0; cyc = 0; we_cyc = 0; we_pulses = 0; seen_rv = 0; shook = 0;
    while (jobs_done < n_jobs && cyc < n_jobs * 200 + 20) begin
      tick();
      cyc++;
      if (we === 1'b1) begin
        we_pulses++;
        we_cyc = cyc;
        seen_rv = 0;
        shook = 0;
        if (rand_ready) rdy = 4'h0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s grant: got unexpected job for id %0d, required no further job", tag, gid);
        end else begin
          exp_g = exp_q.pop_front();
          if (gid !== exp_g) begin
            errors++;
            $display("FAIL %s grant: got id %0d, required %0d", tag, gid, exp_g);
          end
        end
      end
      if (rv !== 4'd0 && !seen_rv) begin
        seen_rv = 1;
        checks++;
        if (cyc - we_cyc != LAT) begin
          errors++;
          $display("FAIL %s latency: got %0d, required %0d", tag, cyc - we_cyc, LAT);
        end
        checks++;
        if (rv !== (4'd1 << gid)) begin
          errors++;
          $display("FAIL %s onehot: got %b, required %b", tag, rv, 4'd1 << gid);
        end
        checks++;
        if (re !== 1'b0) begin
          errors++;
          $display("FAIL %s resp_error: got %b, required 0", tag, re);
        end
      end
      if (rv !== 4'd0 && !shook) begin
        mask = 4'd1 << gid;
        if (!rand_ready || $urandom_range(0, 2) == 0) begin
          rdy = rdy | mask;
          shook = 1;
          jobs_done++;
          ref_count++;
          if (jobs_done == n_jobs) req = 4'h0;
          else if (!hold) req = req & ~mask;
        end
      end
    end
    checks++;
    if (jobs_done != n_jobs) begin
      errors++;
      $display("FAIL %s jobs: got %0d done, required %0d", tag, jobs_done, n_jobs);
    end
    checks++;
    if (we_pulses != n_jobs) begin
      errors++;
      $display("FAIL %s we_pulses: got %0d, required %0d", tag, we_pulses, n_jobs);
    end
    req = 4'h0;
    tick();
    tick();
    checks++;
    if (jc !== ref_count) begin
      errors++;
      $display("FAIL %s job_count: got %0d, required %0d", tag, jc, ref_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got busy %b, required 0", tag, busy);
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'h0;
    rdy = 4'h0;
    #1;
    checks++;
    if ({we, gv, gid, rv, re, te, busy, jc} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {we, gv, gid, rv, re, te, busy, jc});
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, required %0d", state_dbg, IDLE);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || jc !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle: got busy %b count %0d, required 0 0", busy, jc);
    end
  endtask

  task automatic test_single_job();
    do_reset();
    req = 4'b0001;
    rdy = 4'hF;
    for (int n = 0; n <= 70; n++) begin
      tick();
      checks++;
      if (we !== (n == 0)) begin
        errors++;
        $display("FAIL single_we edge %0d: got %b, required %b", n, we, (n == 0));
      end
      checks++;
      if (rv !== ((n == LAT) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL single_rv edge %0d: got %b, required %b", n, rv,
                 (n == LAT) ? 4'b0001 : 4'b0000);
      end
      if (rv[0] === 1'b1) req = 4'h0;
    end
    checks++;
    if (jc !== 16'd1) begin
      errors++;
      $display("FAIL single_count: got %0d, required 1", jc);
    end
    checks++;
    if (re !== 1'b0 || te !== 1'b0) begin
      errors++;
      $display("FAIL single_errors: got %b%b, required 00", re, te);
    end
    ref_count = 16'd1;
    ref_ptr = 1;
  endtask

  task automatic test_two_requests();
    do_reset();
    run_jobs(4'b0101, 1'b0, 2, 1'b0, "two_req");
  endtask

  task automatic test_all_held();
    do_reset();
    run_jobs(4'b1111, 1'b1, 8, 1'b0, "all_held");
  endtask

  task automatic test_backpressure();
    int r, waited;
    logic [15:0] base;
    r = $urandom_range(0, 3);
    base = ref_count;
    req = 4'd1 << r;
    rdy = 4'h0;
    waited = 0;
    while (rv === 4'd0 && waited < 100) begin
      tick();
      waited++;
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (rv !== (4'd1 << r) || gid !== 2'(r) || gv !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: got rv %b id %0d gv %b, required %b %0d 1",
                 n, rv, gid, gv, 4'd1 << r, r);
      end
    end
    rdy = 4'd1 << r;
    req = 4'h0;
    tick();
    checks++;
    if (rv !== 4'd0) begin
      errors++;
      $display("FAIL backpressure_release: got %b, required 0000", rv);
    end
    tick();
    checks++;
    if (jc !== base + 16'd1) begin
      errors++;
      $display("FAIL backpressure_count: got %0d, required %0d", jc, base + 16'd1);
    end
    ref_count = base + 16'd1;
    ref_ptr = (r + 1) % N;
    rdy = 4'h0;
  endtask

  task automatic test_abandon();
    int r, waited;
    r = $urandom_range(0, 3);
    req = 4'd1 << r;
    rdy = 4'h0;
    waited = 0;
    while (rv === 4'd0 && waited < 100) begin
      tick();
      waited++;
    end
    req = 4'h0;
    tick();
    checks++;
    if (rv !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abandon_release: got rv %b busy %b, required 0000 0", rv, busy);
    end
    checks++;
    if (jc !== ref_count) begin
      errors++;
      $display("FAIL abandon_count: got %0d, required %0d", jc, ref_count);
    end
    ref_ptr = (r + 1) % N;
  endtask

  task automatic test_stale_done();
    int first;
    logic re_at;
    do_reset();
    core_mode = 2;
    req = 4'b0010;
    rdy = 4'hF;
    first = -1;
    re_at = 1'b0;
    for (int n = 0; n < 20 && first < 0; n++) begin
      tick();
      if (rv !== 4'd0) begin
        first = n;
        re_at = re;
        req = 4'h0;
      end
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL stale_done_edge: got %0d, required 3", first);
    end
    checks++;
    if (re_at !== 1'b0) begin
      errors++;
      $display("FAIL stale_done_error: got %b, required 0", re_at);
    end
    tick();
    checks++;
    if (jc !== 16'd1) begin
      errors++;
      $display("FAIL stale_done_count: got %0d, required 1", jc);
    end
    core_mode = 0;
    ref_count = 16'd1;
    ref_ptr = 2;
  endtask

  task automatic test_timeout();
    int first;
    logic re_at, te_at;
    logic [15:0] jc_at;
    do_reset();
    core_mode = 1;
    req = 4'b0100;
    rdy = 4'hF;
    first = -1;
    re_at = 1'b0; te_at = 1'b0; jc_at = '0;
    for (int n = 0; n < 100 && first < 0; n++) begin
      tick();
      if (n == TO - 1) begin
        checks++;
        if (te !== 1'b0 || rv !== 4'd0) begin
          errors++;
          $display("FAIL timeout_early: got te %b rv %b, required 0 0000", te, rv);
        end
      end
      if (rv !== 4'd0) begin
        first = n;
        re_at = re; te_at = te; jc_at = jc;
        req = 4'h0;
      end
    end
    checks++;
    if (first != TO) begin
      errors++;
      $display("FAIL timeout_edge: got %0d, required %0d", first, TO);
    end
    checks++;
    if (re_at !== 1'b1 || te_at !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flags: got re %b te %b, required 1 1", re_at, te_at);
    end
    tick();
    checks++;
    if (jc !== 16'd0 || te !== 1'b1 || rv !== 4'd0) begin
      errors++;
      $display("FAIL timeout_after: got count %0d te %b rv %b, required 0 1 0000", jc, te, rv);
    end
    core_mode = 0;
    ref_ptr = 3;
    run_jobs(4'b0001, 1'b0, 1, 1'b0, "after_timeout");
    checks++;
    if (te !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b, required 1", te);
    end
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    req = 4'b0001;
    rdy = 4'hF;
    for (int n = 0; n <= 30; n++) tick();
    checks++;
    if (state_dbg !== WAIT) begin
      errors++;
      $display("FAIL midreset_pre: got state %0d, required %0d", state_dbg, WAIT);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({we, gv, gid, rv, re, te, busy, jc} !== 27'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, required 0", {we, gv, gid, rv, re, te, busy, jc});
    end
    tick();
    tick();
    rst_n = 1'b1;
    ref_ptr = 0;
    ref_count = '0;
    run_jobs(4'b0001, 1'b0, 1, 1'b0, "after_reset");
    checks++;
    if (te !== 1'b0) begin
      errors++;
      $display("FAIL midreset_sticky: got %b, required 0", te);
    end
  endtask

  task automatic test_random();
    logic [3:0] pattern;
    for (int round = 0; round < 6; round++) begin
      pattern = 4'($urandom_range(1, 15));
      run_jobs(pattern, 1'b0, $countones(pattern), 1'b1, "random");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_job();
    test_two_requests();
    test_all_held();
    test_backpressure();
    test_abandon();
    test_stale_done();
    test_timeout();
    test_reset_mid_job();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
